// File: rtl/text_buffer_if.sv
// Bus bundle between the host/display side and the text_buffer screen store.
// Host writes and commands count only on an edge where busy=0. Anything offered while busy=1 is dropped. Nothing retries.
interface text_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] character_pos;
  logic [DATA_W-1:0] character;
  logic [ADDR_W-1:0] write_character_pos;
  logic [DATA_W-1:0] write_character;
  logic              write_strobe;
  logic              cmd_clear;
  logic              cmd_scroll;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;

  modport master (
    output character_pos, write_character_pos, write_character, write_strobe,
           cmd_clear, cmd_scroll, fill_value,
    input  character, busy, done
  );

  modport slave (
    input  character_pos, write_character_pos, write_character, write_strobe,
           cmd_clear, cmd_scroll, fill_value,
    output character, busy, done
  );
endinterface

// File: rtl/text_buffer.sv
// COLS x ROWS character store for the VGA text path.
// It has a registered display read port, a host write port, and a clear / scroll-up engine.
module text_buffer #(
  parameter int DATA_W = 8,
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic         CLK,
  input  logic         RESET_N,
  text_buffer_if.slave bus,
  output logic [2:0]   state_dbg
);
  localparam int DEPTH = COLS * ROWS;
  localparam logic [ADDR_W:0]   DEPTH_X     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A      = ADDR_W'(DEPTH - 1);
  localparam logic              HAS_COPY    = (ROWS > 1);
  localparam logic [ADDR_W-1:0] COPY_LAST_A = ADDR_W'((ROWS > 1) ? (DEPTH - COLS - 1) : 0);
  localparam logic [ADDR_W-1:0] SRC0_A      = ADDR_W'((ROWS > 1) ? COLS : 0);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SCROLL_PRIME, SCROLL_COPY, SCROLL_FILL
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dst_q, dst_d, src_q, src_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] eng_q, character_q;
  logic              done_q, done_d;
  logic              mem_we, eng_re, host_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    src_d   = src_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = bus.write_character_pos;
    mem_wd  = bus.write_character;
    eng_re  = 1'b0;
    host_we = bus.write_strobe && ({1'b0, bus.write_character_pos} < DEPTH_X);
    unique case (state_q)
      IDLE: begin
        // A host write on the accepting edge still lands. Clear takes priority over scroll.
        mem_we = host_we;
        if (bus.cmd_clear) begin
          state_d = CLEAR;
          dst_d   = '0;
          fill_d  = bus.fill_value;
        end else if (bus.cmd_scroll) begin
          state_d = SCROLL_PRIME;
          dst_d   = '0;
          src_d   = SRC0_A;
          fill_d  = bus.fill_value;
        end
      end
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = dst_q;
        mem_wd = fill_q;
        dst_d  = dst_q + 1'b1;
        if (dst_q == LAST_A) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dst_d   = '0;
        end
      end
      SCROLL_PRIME: begin
        // A single-row screen has nothing to copy, so it goes straight to filling row 0.
        eng_re  = HAS_COPY;
        src_d   = src_q + 1'b1;
        state_d = HAS_COPY ? SCROLL_COPY : SCROLL_FILL;
      end
      SCROLL_COPY: begin
        mem_we = 1'b1;
        mem_wa = dst_q;
        mem_wd = eng_q;
        dst_d  = dst_q + 1'b1;
        if (dst_q == COPY_LAST_A) begin
          state_d = SCROLL_FILL;
        end else begin
          eng_re = 1'b1;
          src_d  = src_q + 1'b1;
        end
      end
      SCROLL_FILL: begin
        mem_we = 1'b1;
        mem_wa = dst_q;
        mem_wd = fill_q;
        dst_d  = dst_q + 1'b1;
        if (dst_q == LAST_A) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dst_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      dst_q       <= '0;
      src_q       <= '0;
      fill_q      <= '0;
      done_q      <= 1'b0;
      character_q <= '0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      fill_q      <= fill_d;
      done_q      <= done_d;
      character_q <= ({1'b0, bus.character_pos} < DEPTH_X) ? mem[bus.character_pos] : '0;
    end
  end

  // Reset leaves the array contents alone. It only blocks the write on the reset edge.
  always_ff @(posedge CLK) begin
    if (RESET_N && mem_we) mem[mem_wa] <= mem_wd;
    if (eng_re) eng_q <= mem[src_q];
  end

  assign bus.character = character_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_text_buffer.sv
// Randomised scoreboard bench for text_buffer.
// The reference model is a plain cell array updated by whole-screen clear/scroll rules.
module tb_text_buffer;
  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = COLS * ROWS;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [2:0] state_dbg;

  text_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  text_buffer #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        st_q[$];
  logic rd_issue = 1'b0, st_issue = 1'b0, rd_issue_d = 1'b0, st_issue_d = 1'b0;
  logic [DATA_W-1:0] e_rd;
  logic [1:0]        e_st;

  logic [DATA_W-1:0] model_mem [DEPTH];
  int                eng_left = 0;
  int                elapsed  = 0;
  logic              op_clear = 1'b0;
  logic [DATA_W-1:0] op_fill  = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    rd_issue_d <= rd_issue;
    st_issue_d <= st_issue;
  end

  always @(negedge CLK) begin
    if (rd_issue_d) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL read_underflow: got data %0h expected none queued", bus.character);
      end else begin
        e_rd = exp_q.pop_front();
        check("read", 16'(bus.character), 16'(e_rd));
      end
    end
    if (st_issue_d) begin
      if (st_q.size() == 0) begin
        total++; bad++;
        $display("FAIL status_underflow: got %0b expected none queued", {bus.busy, bus.done});
      end else begin
        e_st = st_q.pop_front();
        check("busy_done", 16'({bus.busy, bus.done}), 16'(e_st));
      end
    end
  end

  task automatic apply_op();
    if (op_clear) begin
      for (int k = 0; k < DEPTH; k++) model_mem[k] = op_fill;
    end else begin
      for (int k = 0; k < DEPTH - COLS; k++) model_mem[k] = model_mem[k + COLS];
      for (int k = DEPTH - COLS; k < DEPTH; k++) model_mem[k] = op_fill;
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [ADDR_W-1:0] wpos,
                       input logic [DATA_W-1:0] wdata, input logic clr, input logic scr,
                       input logic [DATA_W-1:0] fill, input logic rd, input logic [ADDR_W-1:0] rpos);
    logic e_busy, e_done;
    @(negedge CLK);
    RESET_N                 = !rst;
    bus.write_strobe        = wr;
    bus.write_character_pos = wpos;
    bus.write_character     = wdata;
    bus.cmd_clear           = clr;
    bus.cmd_scroll          = scr;
    bus.fill_value          = fill;
    bus.character_pos       = rpos;
    rd_issue                = rd;
    st_issue                = 1'b1;
    if (rd) begin
      if (rst || int'(rpos) >= DEPTH) exp_q.push_back('0);
      else exp_q.push_back(model_mem[int'(rpos)]);
    end
    e_busy = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      // A clear writes cell k on its (k+1)th busy edge, so the cells finished so far keep the fill value.
      if (eng_left > 0 && op_clear)
        for (int k = 0; k < elapsed; k++) model_mem[k] = op_fill;
      eng_left = 0;
    end else if (eng_left > 0) begin
      eng_left--;
      elapsed++;
      if (eng_left == 0) begin
        apply_op();
        e_done = 1'b1;
      end
      e_busy = (eng_left > 0);
    end else begin
      if (wr && int'(wpos) < DEPTH) model_mem[int'(wpos)] = wdata;
      if (clr || scr) begin
        op_clear = clr;
        op_fill  = fill;
        elapsed  = 0;
        eng_left = clr ? DEPTH : DEPTH + 1;
        e_busy   = 1'b1;
      end
    end
    st_q.push_back({e_busy, e_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, 0, '0);
  endtask

  task automatic wr(input int pos, input int d);
    drive(0, 1, ADDR_W'(pos), DATA_W'(d), 0, 0, '0, 0, '0);
  endtask

  task automatic rd(input int pos);
    drive(0, 0, '0, '0, 0, 0, '0, 1, ADDR_W'(pos));
  endtask

  task automatic cmd(input logic c, input logic s, input int f);
    drive(0, 0, '0, '0, c, s, DATA_W'(f), 0, '0);
  endtask

  task automatic settle();
    while (eng_left > 0) idle(1);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) rd(i);
  endtask

  task automatic preload_idx();
    for (int i = 0; i < DEPTH; i++) wr(i, i);
  endtask

  initial begin
    bus.character_pos       = '0;
    bus.write_character_pos = '0;
    bus.write_character     = '0;
    bus.write_strobe        = 1'b0;
    bus.cmd_clear           = 1'b0;
    bus.cmd_scroll          = 1'b0;
    bus.fill_value          = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset held for two edges, then release with no spurious done.
    drive(1, 0, '0, '0, 0, 0, '0, 1, '0);
    drive(1, 0, '0, '0, 0, 0, '0, 1, ADDR_W'(5));
    idle(3);
    for (int i = 0; i < DEPTH; i++) wr(i, 0);

    // Plain write/read, then a same-edge read/write that must return the old value.
    wr(5, 8'h41);
    rd(5);
    drive(0, 1, ADDR_W'(6), 8'h42, 0, 0, '0, 1, ADDR_W'(6));
    rd(6);

    // A clear, with a host write offered mid-clear that must be dropped.
    cmd(1, 0, 8'h20);
    idle(2);
    wr(3, 8'h7F);
    settle();
    read_all();

    // A scroll over a preloaded index pattern.
    preload_idx();
    cmd(0, 1, 8'hFF);
    settle();
    read_all();

    // Clear and scroll together act as a pure clear.
    cmd(1, 1, 8'h55);
    settle();
    read_all();

    // A reset five edges into a clear aborts it with no done.
    preload_idx();
    cmd(1, 0, 8'h55);
    idle(4);
    drive(1, 0, '0, '0, 0, 0, '0, 0, '0);
    idle(1);
    read_all();

    // Out-of-range writes and reads.
    wr(12, 8'hAA);
    wr(15, 8'hBB);
    rd(13);
    read_all();

    // Random traffic, including commands that land while the engine is busy.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic rdv;
      r   = $urandom_range(0, 99);
      rdv = (eng_left == 0) && ($urandom_range(0, 1) == 1);
      drive(0, $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
            r < 3, (r >= 3 && r < 7), DATA_W'($urandom), rdv, ADDR_W'($urandom_range(0, 15)));
    end
    settle();
    read_all();
    idle(2);

    @(negedge CLK);
    rd_issue = 1'b0;
    st_issue = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("drain", 16'(exp_q.size() + st_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
